// File: rtl/uram_write_sequencer_if.sv
// Trigger/write-path bundle between the memclk sequencer and its neighbours.
// master drives run/sync/trigger controls; slave is the sequencer.
interface uram_write_sequencer_if #(
    parameter int ADDR_BITS = 12
);
    logic                 memclk_sync_i;
    logic                 run_i;
    logic                 clear_i;
    logic                 trig_i;
    logic                 trig_ready_i;
    logic [1:0]           phase_o;
    logic                 running_o;
    logic                 wr_en_o;
    logic [ADDR_BITS-1:0] wr_addr_o;
    logic                 trig_valid_o;
    logic [ADDR_BITS-1:0] trig_addr_o;
    logic                 trig_lost_o;
    logic                 sync_err_o;

    modport master (
        output memclk_sync_i, run_i, clear_i, trig_i, trig_ready_i,
        input  phase_o, running_o, wr_en_o, wr_addr_o,
        input  trig_valid_o, trig_addr_o, trig_lost_o, sync_err_o
    );

    modport slave (
        input  memclk_sync_i, run_i, clear_i, trig_i, trig_ready_i,
        output phase_o, running_o, wr_en_o, wr_addr_o,
        output trig_valid_o, trig_addr_o, trig_lost_o, sync_err_o
    );
endinterface

// File: rtl/uram_write_sequencer.sv
// memclk URAM write sequencer: 4-phase groups, wrapping address, trigger capture.
// Optional sticky sync/phase misalignment flag: define URAM_SEQ_SYNC_CHECK_EN.
module uram_write_sequencer #(
    parameter int ADDR_BITS = 12,
    parameter int NPHASE    = 4
) (
    input logic                  memclk_i,
    input logic                  memclk_rstn_i,
    uram_write_sequencer_if.slave bus
);
    localparam int         GW   = ADDR_BITS - 2;
    localparam logic [1:0] LAST = 2'(NPHASE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DRAIN
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            phase_q;
    logic [GW-1:0]         grp_q;
    logic                  tv_q;
    logic [ADDR_BITS-1:0]  ta_q;
    logic                  lost_q;
    logic                  wr_en;
    logic                  last_ph;
    logic                  trig_fire;
    logic                  accept;
    logic [ADDR_BITS-1:0]  wr_addr;

    assign wr_en     = (state_q == RUN) || (state_q == DRAIN);
    assign last_ph   = (phase_q == LAST);
    assign wr_addr   = {grp_q, phase_q};
    assign trig_fire = bus.trig_i && wr_en;
    assign accept    = tv_q && bus.trig_ready_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.run_i) state_d = ARMED;
            end
            ARMED: begin
                if (!bus.run_i)   state_d = IDLE;
                else if (last_ph) state_d = RUN;
            end
            RUN: begin
                if (!bus.run_i) state_d = last_ph ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (last_ph) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
        if (!memclk_rstn_i) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= bus.memclk_sync_i ? 2'd1 : phase_q + 2'd1;
            // Groups advance only after a fully written phase-3 cycle.
            if (wr_en && last_ph)
                grp_q <= grp_q + GW'(1);
            else if (bus.clear_i && state_q == IDLE)
                grp_q <= '0;
        end
    end

    // One-deep holding register; a new capture may replace an accepted entry.
    always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
        if (!memclk_rstn_i) begin
            tv_q   <= 1'b0;
            ta_q   <= '0;
            lost_q <= 1'b0;
        end else begin
            lost_q <= trig_fire && tv_q && !accept;
            if (trig_fire && (!tv_q || accept)) begin
                tv_q <= 1'b1;
                ta_q <= wr_addr;
            end else if (accept) begin
                tv_q <= 1'b0;
            end
        end
    end

`ifdef URAM_SEQ_SYNC_CHECK_EN
    logic err_q;

    always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
        if (!memclk_rstn_i)
            err_q <= 1'b0;
        else if (bus.clear_i)
            err_q <= 1'b0;
        else if (bus.memclk_sync_i && phase_q != 2'd0)
            err_q <= 1'b1;
    end

    assign bus.sync_err_o = err_q;
`else
    assign bus.sync_err_o = 1'b0;
`endif

    assign bus.phase_o      = phase_q;
    assign bus.running_o    = wr_en;
    assign bus.wr_en_o      = wr_en;
    assign bus.wr_addr_o    = wr_addr;
    assign bus.trig_valid_o = tv_q;
    assign bus.trig_addr_o  = ta_q;
    assign bus.trig_lost_o  = lost_q;
endmodule

// File: tb/tb_uram_write_sequencer.sv
// Bench for uram_write_sequencer: vector table through a scoreboard queue,
// plus async-reset and 4-bit address wrap sequences.
module tb_uram_write_sequencer;
`ifdef URAM_SEQ_SYNC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;

    uram_write_sequencer_if #(.ADDR_BITS(12)) m_if ();
    uram_write_sequencer_if #(.ADDR_BITS(4))  s_if ();

    uram_write_sequencer #(.ADDR_BITS(12), .NPHASE(4)) dut (
        .memclk_i      (clk),
        .memclk_rstn_i (rst_n),
        .bus           (m_if)
    );

    uram_write_sequencer #(.ADDR_BITS(4), .NPHASE(4)) dut_s (
        .memclk_i      (clk),
        .memclk_rstn_i (rst_n),
        .bus           (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit s, r, c, t, y;
        int ph, rn, ad, tv, ta, lo, er;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int idx,
                         input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s v%0d act=%0h exp=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input bit s, r, c, t, y,
                       input int ph, rn, ad, tv, ta, lo, er);
        vec_t v;
        v.s = s; v.r = r; v.c = c; v.t = t; v.y = y;
        v.ph = ph; v.rn = rn; v.ad = ad; v.tv = tv;
        v.ta = ta; v.lo = lo; v.er = er & int'(CHK);
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        m_if.memclk_sync_i = v.s;
        m_if.run_i         = v.r;
        m_if.clear_i       = v.c;
        m_if.trig_i        = v.t;
        m_if.trig_ready_i  = v.y;
    endtask

    task automatic compare(input int i, input vec_t e);
        check("phase", i, int'(m_if.phase_o), e.ph);
        check("running", i, int'(m_if.running_o), e.rn);
        check("wr_en", i, int'(m_if.wr_en_o), e.rn);
        check("wr_addr", i, int'(m_if.wr_addr_o), e.ad);
        check("trig_valid", i, int'(m_if.trig_valid_o), e.tv);
        check("trig_addr", i, int'(m_if.trig_addr_o), e.ta);
        check("trig_lost", i, int'(m_if.trig_lost_o), e.lo);
        check("sync_err", i, int'(m_if.sync_err_o), e.er);
    endtask

    initial begin
        vec_t z;
        vec_t e;
        // Idle phase walk, then a sync while phase is already 0.
        add(0,0,0,0,0, 1,0,1, 0,0,0,0);
        add(0,0,0,0,0, 2,0,2, 0,0,0,0);
        add(0,0,0,0,0, 3,0,3, 0,0,0,0);
        add(0,0,0,0,0, 0,0,0, 0,0,0,0);
        add(1,0,0,0,0, 1,0,1, 0,0,0,0);
        // Arm, then first RUN cycle on phase 0.
        add(0,1,0,0,0, 2,0,2, 0,0,0,0);
        add(0,1,0,0,0, 3,0,3, 0,0,0,0);
        add(0,1,0,0,0, 0,1,0, 0,0,0,0);
        for (int a = 1; a <= 5; a++) add(0,1,0,0,0, a%4,1,a, 0,0,0,0);
        // Stop at phase 1; run_i ignored while draining.
        add(0,0,0,0,0, 2,1,6,  0,0,0,0);
        add(0,1,0,0,0, 3,1,7,  0,0,0,0);
        add(0,0,0,0,0, 0,0,8,  0,0,0,0);
        add(0,1,0,0,0, 1,0,9,  0,0,0,0);
        add(0,1,0,0,0, 2,0,10, 0,0,0,0);
        add(0,1,0,0,0, 3,0,11, 0,0,0,0);
        add(0,1,0,0,0, 0,1,8,  0,0,0,0);
        add(0,0,0,0,0, 1,1,9,  0,0,0,0);
        add(0,0,0,0,0, 2,1,10, 0,0,0,0);
        add(0,0,0,0,0, 3,1,11, 0,0,0,0);
        add(0,0,0,0,0, 0,0,12, 0,0,0,0);
        // Clear in IDLE restarts at group 0; clear in RUN is ignored.
        add(0,0,1,0,0, 1,0,1, 0,0,0,0);
        add(0,1,0,0,0, 2,0,2, 0,0,0,0);
        add(0,1,0,0,0, 3,0,3, 0,0,0,0);
        add(0,1,0,0,0, 0,1,0, 0,0,0,0);
        add(0,1,0,0,0, 1,1,1, 0,0,0,0);
        add(0,1,1,0,0, 2,1,2, 0,0,0,0);
        for (int a = 3; a <= 19; a++) add(0,1,0,0,0, a%4,1,a, 0,0,0,0);
        // Trigger at 0x013, lost trigger, accept.
        add(0,1,0,1,0, 0,1,20, 1,19,0,0);
        add(0,1,0,1,0, 1,1,21, 1,19,1,0);
        add(0,1,0,0,0, 2,1,22, 1,19,0,0);
        add(0,1,0,0,1, 3,1,23, 0,19,0,0);
        add(0,1,0,1,0, 0,1,24, 1,23,0,0);
        add(0,1,0,1,1, 1,1,25, 1,24,0,0);
        add(0,1,0,0,1, 2,1,26, 0,24,0,0);
        add(0,0,0,0,0, 3,1,27, 0,24,0,0);
        add(0,0,0,0,0, 0,0,28, 0,24,0,0);
        add(0,0,0,1,0, 1,0,29, 0,24,0,0);
        // Sync misalignment in RUN.
        add(0,1,0,0,0, 2,0,30, 0,24,0,0);
        add(0,1,0,0,0, 3,0,31, 0,24,0,0);
        add(0,1,0,0,0, 0,1,28, 0,24,0,0);
        add(0,1,0,0,0, 1,1,29, 0,24,0,0);
        add(0,1,0,0,0, 2,1,30, 0,24,0,0);
        add(1,1,0,0,0, 1,1,29, 0,24,0,1);
        add(0,1,0,0,0, 2,1,30, 0,24,0,1);
        add(0,1,0,0,0, 3,1,31, 0,24,0,1);
        add(0,1,1,0,0, 0,1,32, 0,24,0,0);
        add(0,1,0,0,0, 1,1,33, 0,24,0,0);
        add(1,1,1,0,0, 1,1,33, 0,24,0,0);
        add(0,1,0,0,0, 2,1,34, 0,24,0,0);
        add(0,1,0,0,0, 3,1,35, 0,24,0,0);
        add(1,1,0,0,0, 1,1,37, 0,24,0,1);
        add(0,1,1,0,0, 2,1,38, 0,24,0,0);

        z = '{default: 0};
        rst_n = 1'b0;
        drive(z);
        s_if.memclk_sync_i = 1'b0;
        s_if.run_i         = 1'b0;
        s_if.clear_i       = 1'b0;
        s_if.trig_i        = 1'b0;
        s_if.trig_ready_i  = 1'b0;
        repeat (3) @(negedge clk);
        compare(-1, z);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            compare(i, e);
        end

        // Async reset mid-RUN clears everything without waiting for an edge.
        #3;
        rst_n = 1'b0;
        #1;
        compare(-2, z);

        // 4-bit address: 5 groups wrap 15 -> 0.
        @(negedge clk);
        drive(z);
        s_if.run_i = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check("small_running", k, int'(s_if.running_o), (k >= 4) ? 1 : 0);
            check("small_addr", k, int'(s_if.wr_addr_o),
                  (k < 4) ? k : (k - 4) % 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uram_write_sequencer.md
Name: uram_write_sequencer

Overview:
Single-clock (memclk) controller that sequences the 4-phase URAM write path fed by the aclk-to-memclk sync transfer.
- Tracks the memclk write phase from the memclk sync pulse.
- Gates URAM write enable on whole 4-phase groups only and generates the wrapping write address.
- Captures trigger addresses into a 1-deep valid/ready holding register for the readout side.

Parameters:
ADDR_BITS, 12, URAM write address width; wr_addr_o = {group counter, phase}, so group counter width = ADDR_BITS-2.
NPHASE, 4, memclk phases per write group; fixed at 4, other values unsupported.

Ports:
memclk_i  input  1  memclk; all logic on rising edge.
memclk_rstn_i  input  1  asynchronous active-low reset.
memclk_sync_i  input  1  1-cycle memclk sync pulse; forces the write phase.
run_i  input  1  level; request to write.
clear_i  input  1  pulse; zeroes the group counter (IDLE only) and clears sync_err_o.
trig_i  input  1  pulse; capture the current write address.
trig_ready_i  input  1  consumer accepts trig_addr_o.
phase_o  output  2  current write phase.
running_o  output  1  state is RUN or DRAIN.
wr_en_o  output  1  URAM write enable.
wr_addr_o  output  ADDR_BITS  URAM write address.
trig_valid_o  output  1  trig_addr_o holds an unconsumed address.
trig_addr_o  output  ADDR_BITS  captured write address.
trig_lost_o  output  1  1-cycle pulse; a trigger was dropped.
sync_err_o  output  1  sticky phase-misalignment flag (optional feature).

Behaviour:
- Reset (async, memclk_rstn_i=0): state IDLE, phase 0, group counter 0, every output 0. Asserting reset mid-run aborts immediately; no drain.
- Phase counter runs in every state. If memclk_sync_i=1, the next phase is 1; otherwise the next phase is phase+1 mod 4.
- Registered FSM:
  - IDLE: run_i=1 -> ARMED.
  - ARMED: run_i=0 -> IDLE. Otherwise, at the edge where phase==3 -> RUN, so the first RUN cycle is phase 0.
  - RUN: run_i=0 and phase==3 -> IDLE. run_i=0 and phase!=3 -> DRAIN. Otherwise stay in RUN.
  - DRAIN: at the edge where phase==3 -> IDLE. run_i is ignored in DRAIN.
- wr_en_o = running_o = (state==RUN || state==DRAIN). Both derive from the state register only, with no combinational path from inputs.
- wr_addr_o = {grp, phase_o}. grp increments, wrapping mod 2^(ADDR_BITS-2), on any edge where wr_en_o=1 and phase==3. grp holds across stop and restart.
- clear_i in IDLE sets grp=0. clear_i in any other state is ignored for grp.
- A sync pulse during RUN jumps phase_o. grp does not increment unless the pre-sync phase was 3 with wr_en_o=1. A group is never left half-written at a stop, because DRAIN exits only after a phase-3 cycle.
- Trigger:
  - trig_i is honoured only when wr_en_o=1; it is ignored otherwise.
  - Capture rule: trig_addr_o <= wr_addr_o of the same cycle, and trig_valid_o=1 from the next cycle.
  - Handshake: trig_valid_o holds, with trig_addr_o stable, until a cycle with trig_valid_o && trig_ready_i. trig_valid_o drops after that edge.
  - Simultaneous accept and new trig_i: the new address is captured and trig_valid_o stays 1. No loss.
  - trig_i while trig_valid_o=1 and not accepted: the held address is kept and trig_lost_o pulses 1 cycle later.
- Outputs change only on memclk_i edges, except the asynchronous reset.

Optional Feature:
URAM_SEQ_SYNC_CHECK_EN
- Defined: sync_err_o is set (sticky) at any memclk_sync_i=1 cycle where phase_o!=0, i.e. where the sync disagrees with the free-running phase. It is cleared by clear_i (clear has priority if both occur in the same cycle) or by reset.
- Not defined: sync_err_o tied 0 and no checker logic is synthesised.

Test Plan:
1. Reset, sync at cycle 5, run_i=1 at cycle 6 -> ARMED; wr_en_o rises on the first phase-0 cycle. wr_addr_o goes 0,1,2,3,4... with phase_o == wr_addr_o[1:0].
2. Drop run_i at phase 1 -> DRAIN; wr_en_o stays high through phase 3, then IDLE. Restart continues at the next grp (addr 8 after groups 0 and 1); clear_i in IDLE then restarts at 0.
3. ADDR_BITS=4, run 5 groups -> wr_addr_o wraps 15 -> 0 and grp wraps 3 -> 0.
4. trig_i at wr_addr_o=0x013 with trig_ready_i=0 -> trig_valid_o=1, trig_addr_o=0x013. Second trig_i -> trig_lost_o pulse, addr stays 0x013. trig_ready_i=1 -> valid drops.
5. trig_i in the same cycle as an accept -> new address captured, trig_valid_o stays 1, trig_lost_o=0. trig_i in IDLE -> no capture.
6. With URAM_SEQ_SYNC_CHECK_EN: sync while phase_o=2 in RUN -> phase_o=1 next, sync_err_o=1 sticky; clear_i -> 0. Without the macro, sync_err_o stays 0. Reset asserted mid-RUN -> all outputs 0 immediately.
